// File: rtl/cdu_count_receiver.sv
// CDU incremental-angle receiver: synchronizes PCDU/MCDU pulse trains, nets them into a
// signed pending count and drains it into the angle counter one granted counter cycle at a time.
module cdu_count_receiver #(
    parameter int WIDTH       = 15,
    parameter int SYNC_STAGES = 2,
    parameter int PEND_MAX    = 7
) (
    input  logic             _51KPHI,
    input  logic             rst_n,
    input  logic             PCDU,
    input  logic             MCDU,
    input  logic             CCDUZ,
    output logic             cnt_req,
    input  logic             cnt_gnt,
    output logic             cnt_dir,
    output logic [WIDTH-1:0] angle,
    output logic [4:0]       pend,
    output logic             lost
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam logic signed [5:0] P_MAX = 6'(PEND_MAX);
    localparam logic signed [5:0] N_MAX = -6'(PEND_MAX);

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [WIDTH-1:0]       angle_q, angle_d;
    logic [4:0]             pend_q, pend_d;
    logic                   lost_q, lost_d;
    logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d, m_sync_q, m_sync_d;
    logic                   p_hist_q, p_hist_d, m_hist_q, m_hist_d;

    logic                   p_ev, m_ev, grant;
    logic signed [5:0]      svc, base, nxt;

    always_comb begin
        p_sync_d = {p_sync_q[SYNC_STAGES-2:0], PCDU};
        m_sync_d = {m_sync_q[SYNC_STAGES-2:0], MCDU};
        p_hist_d = p_sync_q[SYNC_STAGES-1];
        m_hist_d = m_sync_q[SYNC_STAGES-1];
        p_ev     = p_sync_q[SYNC_STAGES-1] & ~p_hist_q;
        m_ev     = m_sync_q[SYNC_STAGES-1] & ~m_hist_q;

        state_d  = state_q;
        dir_d    = dir_q;
        angle_d  = angle_q;
        lost_d   = lost_q;
        grant    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 5'd0) begin
                    state_d = S_REQ;
                    dir_d   = pend_q[4];
                end
            end
            S_REQ: begin
                if (cnt_gnt) begin
                    grant   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            angle_d = dir_q ? angle_q - WIDTH'(1) : angle_q + WIDTH'(1);
        end

        // Saturation is judged after the service term so a granted count frees room this cycle.
        svc  = grant ? (dir_q ? -6'sd1 : 6'sd1) : 6'sd0;
        base = $signed({pend_q[4], pend_q}) - svc;
        nxt  = base;
        if (p_ev && !m_ev) begin
            if (base >= P_MAX) lost_d = 1'b1;
            else               nxt    = base + 6'sd1;
        end else if (m_ev && !p_ev) begin
            if (base <= N_MAX) lost_d = 1'b1;
            else               nxt    = base - 6'sd1;
        end
        pend_d = nxt[4:0];

        // Clear wins over grants and pulse events; the synchronizers keep running.
        if (CCDUZ) begin
            angle_d = '0;
            pend_d  = '0;
            lost_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge _51KPHI or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            angle_q  <= '0;
            pend_q   <= '0;
            lost_q   <= 1'b0;
            p_sync_q <= '0;
            m_sync_q <= '0;
            p_hist_q <= 1'b0;
            m_hist_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            angle_q  <= angle_d;
            pend_q   <= pend_d;
            lost_q   <= lost_d;
            p_sync_q <= p_sync_d;
            m_sync_q <= m_sync_d;
            p_hist_q <= p_hist_d;
            m_hist_q <= m_hist_d;
        end
    end

    assign cnt_req = (state_q == S_REQ);
    assign cnt_dir = dir_q;
    assign angle   = angle_q;
    assign pend    = pend_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_cdu_count_receiver.sv
// Bench for cdu_count_receiver: directed pulse scenarios, expected count directions queued
// at stimulus time and popped by a monitor on every granted counter cycle.
module tb_cdu_count_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_in = 1'b0;
    logic        m_in = 1'b0;
    logic        clr = 1'b0;
    logic        gnt = 1'b0;
    logic        cnt_req, cnt_dir, lost;
    logic [14:0] angle;
    logic [4:0]  pend;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_cycles = 0;
    int          grants = 0;
    logic [0:0]  exp_q[$];

    cdu_count_receiver #(.WIDTH(15), .SYNC_STAGES(2), .PEND_MAX(7)) dut (
        ._51KPHI (clk),
        .rst_n   (rst_n),
        .PCDU    (p_in),
        .MCDU    (m_in),
        .CCDUZ   (clr),
        .cnt_req (cnt_req),
        .cnt_gnt (gnt),
        .cnt_dir (cnt_dir),
        .angle   (angle),
        .pend    (pend),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic minus);
        if (minus) m_in = 1'b1;
        else       p_in = 1'b1;
        tick; tick;
        p_in = 1'b0;
        m_in = 1'b0;
        tick; tick;
    endtask

    task automatic clear_cdu;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        tick;
    endtask

    // Monitor: every applied count must match the oldest queued direction.
    always @(negedge clk) begin
        if (rst_n && cnt_req) req_cycles++;
        if (rst_n && cnt_req && gnt && !clr) begin
            grants++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL grant_dir: unexpected count dir=%0d, expected none", cnt_dir);
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                if (cnt_dir !== e) begin
                    tests_failed++;
                    $display("FAIL grant_dir: got %0d expected %0d", cnt_dir, e);
                end
            end
        end
    end

    initial begin
        int lat;
        int r0, g0;
        logic any_req, any_pend;

        repeat (3) tick;
        check("reset_angle", 32'(angle), 32'h0);
        check("reset_pend", 32'(pend), 32'h0);
        check("reset_lost", 32'(lost), 32'h0);
        check("reset_req", 32'(cnt_req), 32'h0);
        check("reset_dir", 32'(cnt_dir), 32'h0);
        rst_n = 1'b1;
        tick;

        // 5 plus pulses, grant tied high; measure first request latency.
        gnt = 1'b1;
        r0 = req_cycles;
        g0 = grants;
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b0);
        lat = 0;
        p_in = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (n == 2) p_in = 1'b0;
            if (cnt_req && lat == 0) begin
                lat = n;
                break;
            end
        end
        check("first_req_latency", 32'(lat), 32'd4);
        tick;
        for (int i = 0; i < 4; i++) pulse(1'b0);
        repeat (20) tick;
        check("t1_angle", 32'(angle), 32'd5);
        check("t1_pend", 32'(pend), 32'h0);
        check("t1_lost", 32'(lost), 32'h0);
        check("t1_req_cycles", 32'(req_cycles - r0), 32'd5);
        check("t1_grants", 32'(grants - g0), 32'd5);

        // Preload angle to 1, then 3 minus counts wrap through zero.
        clear_cdu;
        exp_q.push_back(1'b0);
        pulse(1'b0);
        repeat (10) tick;
        check("t2_preload", 32'(angle), 32'h1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1'b1);
            pulse(1'b1);
        end
        repeat (15) tick;
        check("t2_wrap_angle", 32'(angle), 32'h7FFE);
        check("t2_pend", 32'(pend), 32'h0);

        // Simultaneous plus and minus edges cancel.
        any_req = 1'b0;
        any_pend = 1'b0;
        p_in = 1'b1;
        m_in = 1'b1;
        tick; tick;
        p_in = 1'b0;
        m_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (cnt_req) any_req = 1'b1;
            if (pend != 5'd0) any_pend = 1'b1;
        end
        check("t4_no_req", 32'(any_req), 32'h0);
        check("t4_no_pend", 32'(any_pend), 32'h0);
        check("t4_angle", 32'(angle), 32'h7FFE);
        check("t4_lost", 32'(lost), 32'h0);

        // Saturation with grant withheld, then drain.
        clear_cdu;
        gnt = 1'b0;
        for (int i = 0; i < 10; i++) pulse(1'b0);
        check("t3_pend_sat", 32'(pend), 32'd7);
        check("t3_lost", 32'(lost), 32'h1);
        check("t3_req_held", 32'(cnt_req), 32'h1);
        check("t3_dir", 32'(cnt_dir), 32'h0);
        for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
        gnt = 1'b1;
        repeat (40) tick;
        check("t3_angle", 32'(angle), 32'd7);
        check("t3_pend_drained", 32'(pend), 32'h0);
        check("t3_lost_sticky", 32'(lost), 32'h1);

        // Opposite pulses during a held request.
        clear_cdu;
        gnt = 1'b0;
        exp_q.push_back(1'b0);
        pulse(1'b0);
        tick; tick; tick;
        check("t5_req_held", 32'(cnt_req), 32'h1);
        exp_q.push_back(1'b1);
        pulse(1'b1);
        exp_q.push_back(1'b1);
        pulse(1'b1);
        check("t5_pend_before", 32'(pend), 32'h1F);
        check("t5_req_kept", 32'(cnt_req), 32'h1);
        gnt = 1'b1;
        tick;
        check("t5_angle_after_grant", 32'(angle), 32'h1);
        check("t5_pend_after_grant", 32'(pend), 32'h1E);
        repeat (15) tick;
        check("t5_final_angle", 32'(angle), 32'h7FFF);
        check("t5_final_pend", 32'(pend), 32'h0);

        // Build angle 0x1234, set lost, then clear in the same cycle as a grant.
        clear_cdu;
        for (int i = 0; i < 32'h1234; i++) begin
            exp_q.push_back(1'b0);
            pulse(1'b0);
        end
        repeat (10) tick;
        check("t6_angle_built", 32'(angle), 32'h1234);
        gnt = 1'b0;
        for (int i = 0; i < 10; i++) pulse(1'b0);
        check("t6_lost_set", 32'(lost), 32'h1);
        check("t6_angle_held", 32'(angle), 32'h1234);
        clr = 1'b1;
        gnt = 1'b1;
        tick;
        check("t6_clr_angle", 32'(angle), 32'h0);
        check("t6_clr_pend", 32'(pend), 32'h0);
        check("t6_clr_lost", 32'(lost), 32'h0);
        check("t6_clr_req", 32'(cnt_req), 32'h0);
        clr = 1'b0;
        gnt = 1'b0;
        repeat (5) tick;
        check("t6_angle_stays", 32'(angle), 32'h0);

        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cdu_count_receiver.md
Name: cdu_count_receiver

Overview:
- Computer-side receiver for the incremental angle pulse trains (PCDU plus, MCDU minus) that the CDU digital mode logic emits at up to 800 pps per axis.
- Synchronizes and edge-detects both lines and nets them into a signed pending count.
- Drains the pending count into a 15-bit angle counter through a request/grant counter-cycle handshake, one count per granted cycle.
- One instance per CDU axis; sits between the CDU interface pins and the counter-priority arbiter.

Parameters:
- WIDTH, 15, angle counter width (two's complement angle, modulo 2^WIDTH).
- SYNC_STAGES, 2, flops per input synchronizer chain (minimum 2).
- PEND_MAX, 7, pending-count saturation magnitude for newly detected pulses.

Ports:
- _51KPHI  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset: asynchronous assert, active-low.
- PCDU  input  1  plus-count pulse from the CDU; asynchronous level, at least 2 clock periods high and 2 low.
- MCDU  input  1  minus-count pulse from the CDU; same timing as PCDU.
- CCDUZ  input  1  synchronous clear (zero CDU counter), active-high.
- cnt_req  output  1  counter-cycle request to the arbiter.
- cnt_gnt  input  1  counter-cycle grant; meaningful only while cnt_req=1.
- cnt_dir  output  1  direction of the requested count, 0=plus, 1=minus; valid while cnt_req=1.
- angle  output  WIDTH  accumulated angle counter.
- pend  output  5  signed two's complement net pending count, range -(PEND_MAX+1)..+(PEND_MAX+1).
- lost  output  1  sticky flag: a pulse was dropped at saturation.

Behaviour:
- Reset (rst_n=0, asynchronous): angle=0, pend=0, lost=0, cnt_req=0, cnt_dir=0, FSM=IDLE, synchronizer and edge-history flops=0.
- Input path:
  - PCDU and MCDU each pass through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge is a 1-cycle event.
  - Latency from the pin rising to the event is SYNC_STAGES+1 cycles.
- Pending update each cycle:
  - pend_next = pend + plus_ev - minus_ev - svc, where svc = +1 (plus grant), -1 (minus grant) or 0.
  - Plus and minus events in the same cycle cancel; lost is not set.
  - A plus event is dropped when (pend - svc) >= +PEND_MAX. A minus event is dropped when (pend - svc) <= -PEND_MAX. A dropped event sets lost=1.
  - The svc term may push pend one step past the opposite limit (see REQ); the 5-bit width covers this.
- FSM, three states:
  - IDLE:
    - pend>0: go to REQ, cnt_dir=0.
    - pend<0: go to REQ, cnt_dir=1.
    - pend=0: stay in IDLE.
    - cnt_req=1 exactly while in REQ.
  - REQ:
    - cnt_req=1; cnt_dir is held stable for the whole request.
    - cnt_gnt=1 at a clock edge: apply the count at that edge, then go to GAP.
      - angle = angle ± 1, modulo 2^WIDTH: 0x7FFF+1 → 0x0000; 0x0000-1 → 0x7FFF.
      - pend adjusted by svc.
    - cnt_gnt=0: stay in REQ indefinitely.
    - Opposite pulses arriving during REQ do not withdraw the request. The granted count is still applied and pend absorbs the difference (for example, pend 0 → -1), so the net angle stays correct.
  - GAP:
    - cnt_req=0 for exactly one cycle, then IDLE.
    - Minimum spacing is 3 cycles per count (IDLE→REQ→GAP with an immediate grant).
- cnt_gnt while cnt_req=0 is ignored.
- CCDUZ=1 (synchronous, overrides everything including a same-cycle grant and pulse events):
  - Next edge: angle=0, pend=0, lost=0, FSM=IDLE, so cnt_req=0 on the next cycle.
  - Synchronizer flops keep running, so a pulse in flight is still detected after the clear.
- Reset mid-handshake: cnt_req drops immediately (asynchronous); no count is applied.
- lost clears only on reset or CCDUZ.

Test Plan:
- Reset, then 5 PCDU pulses with cnt_gnt tied 1 → 5 requests, each cnt_req high 1 cycle, cnt_dir=0; angle=5, pend=0, lost=0; first cnt_req rises SYNC_STAGES+2 cycles after the first PCDU rise.
- angle preloaded to 0x0001 via pulses, then 3 MCDU pulses with grant tied 1 → angle=0x7FFE (wrap through 0), cnt_dir=1 on all requests.
- cnt_gnt held 0, then 10 PCDU pulses → pend saturates at +7, lost=1, cnt_req=1 steady; release grant → exactly 7 counts applied, angle=7.
- PCDU and MCDU rising in the same cycle → no pend change, no request, angle unchanged, lost=0.
- pend=+1, REQ held without grant, then 2 MCDU pulses, then grant → angle=+1 after the plus count, pend=-2, then two minus counts drain it → final angle=-1 (0x7FFF), pend=0.
- CCDUZ asserted in the same cycle as cnt_gnt with angle=0x1234 and lost=1 → next cycle angle=0, pend=0, lost=0, cnt_req=0; the grant is not applied.
